// File: rtl/reg_writeback.sv
// reg_writeback: register-file write-port driver.
// Merges never-stalled ALU results with handshaked load results. Loads that
// collide with an ALU write wait in a small FIFO; an ALU write kills any
// older buffered load to the same register so write-after-write order holds.

// One load-buffer entry: dest/data/live plus the kill and query compares.
module reg_wb_entry #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr,
  input  logic [AW-1:0] wr_dest,
  input  logic [DW-1:0] wr_data,
  input  logic          wr_live,
  input  logic          clr,
  input  logic          kill,
  input  logic [AW-1:0] kill_dest,
  input  logic [AW-1:0] query_reg,
  output logic [AW-1:0] dest,
  output logic [DW-1:0] data,
  output logic          live,
  output logic          hit
);

  // Fill on push; drop live on pop or when a younger ALU write targets dest.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dest <= '0;
      data <= '0;
      live <= 1'b0;
    end else if (wr) begin
      dest <= wr_dest;
      data <= wr_data;
      live <= wr_live;
    end else if (clr) begin
      live <= 1'b0;
    end else if (kill && (dest == kill_dest)) begin
      live <= 1'b0;
    end
  end

  assign hit = live && (dest == query_reg);

endmodule

module reg_writeback #(
  parameter int DW    = 8,
  parameter int AW    = 3,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_dest,
  input  logic [DW-1:0] alu_data,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [AW-1:0] ld_dest,
  input  logic [DW-1:0] ld_data,
  output logic          regWrite,
  output logic [AW-1:0] writeReg,
  output logic [DW-1:0] writeData,
  input  logic [AW-1:0] query_reg,
  output logic          query_hit,
  output logic          busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;

  logic [DEPTH-1:0][AW-1:0] ent_dest;
  logic [DEPTH-1:0][DW-1:0] ent_data;
  logic [DEPTH-1:0]         ent_live, ent_hit, ent_wr, ent_clr;

  logic full, empty, accept, pop, bypass, push, push_live;

  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  // No same-cycle refill: a full buffer refuses even if it pops this cycle.
  assign ld_ready = !full;
  assign accept = ld_valid && ld_ready;

  // Issue priority: ALU, then buffer head, then bypass of a fresh load.
  assign pop    = !alu_valid && !empty;
  assign bypass = !alu_valid && empty && accept;
  assign push   = accept && !bypass;
  // A load arriving alongside an ALU write to the same reg is the older one.
  assign push_live = !(alu_valid && (ld_dest == alu_dest));

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    assign ent_wr[i]  = push && (tail == PW'(i));
    assign ent_clr[i] = pop  && (head == PW'(i));
    reg_wb_entry #(.DW(DW), .AW(AW)) u_ent (
      .clk       (clk),
      .reset     (reset),
      .wr        (ent_wr[i]),
      .wr_dest   (ld_dest),
      .wr_data   (ld_data),
      .wr_live   (push_live),
      .clr       (ent_clr[i]),
      .kill      (alu_valid),
      .kill_dest (alu_dest),
      .query_reg (query_reg),
      .dest      (ent_dest[i]),
      .data      (ent_data[i]),
      .live      (ent_live[i]),
      .hit       (ent_hit[i])
    );
  end

  assign query_hit = |ent_hit;
  assign busy      = !empty || regWrite;

  // FIFO pointers and occupancy; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Registered write port; a dead pop burns the slot with regWrite low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regWrite  <= 1'b0;
      writeReg  <= '0;
      writeData <= '0;
    end else if (alu_valid) begin
      regWrite  <= 1'b1;
      writeReg  <= alu_dest;
      writeData <= alu_data;
    end else if (pop) begin
      regWrite  <= ent_live[head];
      writeReg  <= ent_dest[head];
      writeData <= ent_data[head];
    end else if (bypass) begin
      regWrite  <= 1'b1;
      writeReg  <= ld_dest;
      writeData <= ld_data;
    end else begin
      regWrite  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_writeback.sv
// Bench for reg_writeback: directed scenarios with spec-derived constants,
// then randomized traffic checked against a queue-based reference model.
module tb_reg_writeback;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic alu_valid = 1'b0;
  logic [AW-1:0] alu_dest = '0;
  logic [DW-1:0] alu_data = '0;
  logic ld_valid = 1'b0;
  logic ld_ready;
  logic [AW-1:0] ld_dest = '0;
  logic [DW-1:0] ld_data = '0;
  logic regWrite;
  logic [AW-1:0] writeReg;
  logic [DW-1:0] writeData;
  logic [AW-1:0] query_reg = '0;
  logic query_hit;
  logic busy;

  int checks = 0;
  int errors = 0;

  reg_writeback #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_dest(ld_dest), .ld_data(ld_data),
    .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
    .query_reg(query_reg), .query_hit(query_hit), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic av, input logic [AW-1:0] ad, input logic [DW-1:0] adat,
                        input logic lv, input logic [AW-1:0] ldd, input logic [DW-1:0] lddat);
    alu_valid = av; alu_dest = ad; alu_data = adat;
    ld_valid = lv; ld_dest = ldd; ld_data = lddat;
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 0, 0);
    query_reg = 0;
    @(posedge clk); #1;
    reset = 1'b1;
    #3;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    set_in(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    #1;
    checks++; if (regWrite !== 1'b0) begin errors++; $display("FAIL reset_regWrite got %b want 0", regWrite); end
    checks++; if (writeReg !== 3'd0) begin errors++; $display("FAIL reset_writeReg got %0d want 0", writeReg); end
    checks++; if (writeData !== 8'h00) begin errors++; $display("FAIL reset_writeData got %0h want 0", writeData); end
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL reset_ld_ready got %b want 1", ld_ready); end
    checks++; if (query_hit !== 1'b0) begin errors++; $display("FAIL reset_query_hit got %b want 0", query_hit); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    @(posedge clk); #2;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_alu();
    do_reset();
    set_in(1, 3, 8'h5A, 0, 0, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0);
    checks++; if ({regWrite, writeReg, writeData} !== {1'b1, 3'd3, 8'h5A})
      begin errors++; $display("FAIL alu_write got %b/%0d/%0h want 1/3/5a", regWrite, writeReg, writeData); end
    tick();
    checks++; if (regWrite !== 1'b0) begin errors++; $display("FAIL alu_idle_rw got %b want 0", regWrite); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL alu_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_bypass();
    do_reset();
    query_reg = 2;
    set_in(0, 0, 0, 1, 2, 8'h11);
    #1;
    checks++; if (query_hit !== 1'b0) begin errors++; $display("FAIL bypass_qhit0 got %b want 0", query_hit); end
    tick();
    set_in(0, 0, 0, 0, 0, 0);
    checks++; if ({regWrite, writeReg, writeData} !== {1'b1, 3'd2, 8'h11})
      begin errors++; $display("FAIL bypass_write got %b/%0d/%0h want 1/2/11", regWrite, writeReg, writeData); end
    checks++; if (query_hit !== 1'b0) begin errors++; $display("FAIL bypass_qhit1 got %b want 0", query_hit); end
    tick();
    checks++; if (regWrite !== 1'b0) begin errors++; $display("FAIL bypass_idle got %b want 0", regWrite); end
  endtask

  task automatic test_starve();
    do_reset();
    query_reg = 5;
    set_in(1, 1, 8'h10, 1, 4, 8'hA0);             // cycle 1
    tick();
    set_in(1, 1, 8'h20, 1, 5, 8'hB0);             // cycle 2
    #1;
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL starve_ready_c2 got %b want 1", ld_ready); end
    tick();
    set_in(1, 1, 8'h30, 0, 0, 0);                 // cycle 3
    #1;
    checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL starve_ready_c3 got %b want 0", ld_ready); end
    checks++; if (query_hit !== 1'b1) begin errors++; $display("FAIL starve_qhit_c3 got %b want 1", query_hit); end
    tick();
    set_in(1, 1, 8'h40, 0, 0, 0);                 // cycle 4
    tick();
    set_in(0, 0, 0, 0, 0, 0);                     // cycle 5
    checks++; if ({regWrite, writeReg, writeData} !== {1'b1, 3'd1, 8'h40})
      begin errors++; $display("FAIL starve_c5 got %b/%0d/%0h want 1/1/40", regWrite, writeReg, writeData); end
    checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL starve_ready_c5 got %b want 0", ld_ready); end
    tick();                                       // cycle 6
    checks++; if ({regWrite, writeReg, writeData} !== {1'b1, 3'd4, 8'hA0})
      begin errors++; $display("FAIL starve_c6 got %b/%0d/%0h want 1/4/a0", regWrite, writeReg, writeData); end
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL starve_ready_c6 got %b want 1", ld_ready); end
    tick();                                       // cycle 7
    checks++; if ({regWrite, writeReg, writeData} !== {1'b1, 3'd5, 8'hB0})
      begin errors++; $display("FAIL starve_c7 got %b/%0d/%0h want 1/5/b0", regWrite, writeReg, writeData); end
    checks++; if (query_hit !== 1'b0) begin errors++; $display("FAIL starve_qhit_c7 got %b want 0", query_hit); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL starve_busy_c8 got %b want 0", busy); end
  endtask

  task automatic test_waw_kill();
    do_reset();
    query_reg = 6;
    set_in(1, 0, 8'h33, 1, 6, 8'h77);             // load buffered behind ALU
    tick();
    set_in(1, 6, 8'h99, 0, 0, 0);
    #1;
    checks++; if (query_hit !== 1'b1) begin errors++; $display("FAIL waw_qhit_before got %b want 1", query_hit); end
    tick();
    set_in(0, 0, 0, 0, 0, 0);
    checks++; if ({regWrite, writeReg, writeData} !== {1'b1, 3'd6, 8'h99})
      begin errors++; $display("FAIL waw_alu got %b/%0d/%0h want 1/6/99", regWrite, writeReg, writeData); end
    checks++; if (query_hit !== 1'b0) begin errors++; $display("FAIL waw_qhit_after got %b want 0", query_hit); end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (regWrite !== 1'b0) begin errors++; $display("FAIL waw_dead_pop%0d got rw=%b reg=%0d data=%0h want rw=0", c, regWrite, writeReg, writeData); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL waw_busy got %b want 0", busy); end
  endtask

  task automatic test_same_cycle_kill();
    do_reset();
    query_reg = 7;
    set_in(1, 7, 8'h01, 1, 7, 8'h02);
    #1;
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL same_handshake got %b want 1", ld_ready); end
    tick();
    set_in(0, 0, 0, 0, 0, 0);
    checks++; if ({regWrite, writeReg, writeData} !== {1'b1, 3'd7, 8'h01})
      begin errors++; $display("FAIL same_alu got %b/%0d/%0h want 1/7/01", regWrite, writeReg, writeData); end
    checks++; if (query_hit !== 1'b0) begin errors++; $display("FAIL same_qhit got %b want 0", query_hit); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL same_busy got %b want 1", busy); end
    tick();
    checks++; if (regWrite !== 1'b0) begin errors++; $display("FAIL same_dead_pop got %b want 0", regWrite); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL same_busy_end got %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    query_reg = 1;
    set_in(1, 0, 8'h55, 1, 1, 8'hC1);
    tick();
    set_in(1, 0, 8'h66, 1, 2, 8'hC2);
    tick();
    set_in(1, 3, 8'h77, 0, 0, 0);
    #1;
    checks++; if ({ld_ready, query_hit} !== 2'b01) begin errors++; $display("FAIL rmid_full got ready=%b hit=%b want 0/1", ld_ready, query_hit); end
    #1;
    reset = 1'b1;
    #1;
    checks++; if ({regWrite, writeReg, writeData} !== {1'b0, 3'd0, 8'h00})
      begin errors++; $display("FAIL rmid_outs got %b/%0d/%0h want 0/0/0", regWrite, writeReg, writeData); end
    checks++; if ({busy, query_hit, ld_ready} !== 3'b001)
      begin errors++; $display("FAIL rmid_status got busy=%b hit=%b ready=%b want 0/0/1", busy, query_hit, ld_ready); end
    set_in(0, 0, 0, 0, 0, 0);
    #1;
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++; if ({regWrite, busy} !== 2'b00) begin errors++; $display("FAIL rmid_after%0d got rw=%b busy=%b want 0/0", c, regWrite, busy); end
    end
  endtask

  typedef struct {
    logic [AW-1:0] dest;
    logic [DW-1:0] data;
    bit            live;
  } ent_t;

  task automatic test_random();
    ent_t q[$];
    ent_t e;
    bit m_rw;
    logic [AW-1:0] m_reg;
    logic [DW-1:0] m_data;
    bit m_ready, m_hit, acc;
    do_reset();
    m_rw = 0; m_reg = 0; m_data = 0;
    for (int n = 0; n < 400; n++) begin
      set_in(($urandom_range(0, 99) < 55), AW'($urandom_range(0, 3)), DW'($urandom),
             ($urandom_range(0, 99) < 65), AW'($urandom_range(0, 3)), DW'($urandom));
      query_reg = AW'($urandom_range(0, 3));
      #1;
      m_ready = (q.size() < DEPTH);
      m_hit = 0;
      foreach (q[k]) if (q[k].live && q[k].dest == query_reg) m_hit = 1;
      checks++; if (ld_ready !== m_ready) begin errors++; $display("FAIL rnd_ready n=%0d got %b want %b", n, ld_ready, m_ready); end
      checks++; if (query_hit !== m_hit) begin errors++; $display("FAIL rnd_qhit n=%0d got %b want %b", n, query_hit, m_hit); end
      checks++; if (busy !== ((q.size() != 0) || m_rw)) begin errors++; $display("FAIL rnd_busy n=%0d got %b", n, busy); end
      acc = ld_valid && m_ready;
      if (alu_valid) begin
        foreach (q[k]) if (q[k].dest == alu_dest) q[k].live = 0;
        m_rw = 1; m_reg = alu_dest; m_data = alu_data;
        if (acc) q.push_back('{ld_dest, ld_data, (ld_dest != alu_dest)});
      end else if (q.size() != 0) begin
        e = q.pop_front();
        m_rw = e.live; m_reg = e.dest; m_data = e.data;
        if (acc) q.push_back('{ld_dest, ld_data, 1'b1});
      end else if (acc) begin
        m_rw = 1; m_reg = ld_dest; m_data = ld_data;
      end else begin
        m_rw = 0;
      end
      tick();
      checks++; if (regWrite !== m_rw) begin errors++; $display("FAIL rnd_rw n=%0d got %b want %b", n, regWrite, m_rw); end
      if (m_rw) begin
        checks++; if ({writeReg, writeData} !== {m_reg, m_data})
          begin errors++; $display("FAIL rnd_wr n=%0d got %0d/%0h want %0d/%0h", n, writeReg, writeData, m_reg, m_data); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_bypass();
    test_starve();
    test_waw_kill();
    test_same_cycle_kill();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_writeback.md
# reg_writeback

Write-port driver for the 8x8 register file: the single initiator on its `regWrite`/`writeReg`/`writeData` port. Merges two result sources onto that port: single-cycle ALU results, which are never stalled, and memory-load results, which use a valid/ready handshake and wait in a small FIFO when they collide with ALU writes. Preserves write-after-write order per register and exposes a pending-write query for the hazard logic in decode.

## Interface
- `DW`, 8, data width (matches register width)
- `AW`, 3, register address width (8 registers)
- `DEPTH`, 2, load buffer entries (power of two, ≥2)

- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `alu_valid`  in  1  ALU result present this cycle; no backpressure
- `alu_dest`  in  AW  ALU destination register
- `alu_data`  in  DW  ALU result
- `ld_valid`  in  1  load result offered
- `ld_ready`  out  1  load buffer can accept; equals !full
- `ld_dest`  in  AW  load destination register
- `ld_data`  in  DW  load data
- `regWrite`  out  1  register file write enable (registered)
- `writeReg`  out  AW  register file write address (registered)
- `writeData`  out  DW  register file write data (registered)
- `query_reg`  in  AW  register to check for a pending load write
- `query_hit`  out  1  a live buffered load targets `query_reg` (combinational)
- `busy`  out  1  buffer non-empty or `regWrite` high

## Operation
- Load accepted when `ld_valid && ld_ready`. Each buffer entry holds dest, data and a live bit.
- Per-cycle issue priority:
  1. `alu_valid`: drive the ALU write.
  2. Otherwise, buffer non-empty: pop the head. If it is live, drive its write; if dead, `regWrite`=0 that cycle.
  3. Otherwise, buffer empty and a load accepted this cycle: bypass. The load is issued directly and never enters the buffer.
  4. Otherwise: no write.
- An accepted load that is not bypassed is pushed at the tail, live=1.
- WAW kill rule: when `alu_valid`, every buffered entry with dest == `alu_dest` has its live bit cleared. A load accepted in the same cycle with `ld_dest == alu_dest` is treated as older:
  - it is pushed dead;
  - the handshake still completes.
- Push and pop in the same cycle are allowed when not full.
- When full, `ld_ready`=0 even if a pop occurs that cycle (no same-cycle refill).
- Pointers wrap modulo `DEPTH`. Occupancy counter is 0..DEPTH.
- `query_hit` = OR over live entries of (dest == `query_reg`). It excludes the output register stage.
- `busy` = (count != 0) || `regWrite`.

## Timing
- Reset values:
  - `regWrite`=0, `writeReg`=0, `writeData`=0;
  - count=0, all live bits 0;
  - `ld_ready`=1, `query_hit`=0, `busy`=0.
- ALU latency: `alu_valid` in cycle N → `regWrite`=1 with that dest/data in cycle N+1. The write commits to the register file at the end of N+1.
- Bypassed load: accepted in N → written in N+1.
- Buffered load: popped in M → written in M+1. Minimum accept-to-write is 2 cycles.
- Sustained `alu_valid` starves loads indefinitely. Once full, `ld_ready` stays 0 until the first non-ALU cycle pops an entry; `ld_ready` returns to 1 the following cycle.
- Reset asserted mid-operation: within the same cycle,
  - outputs return to reset values;
  - buffered loads are discarded;
  - no partial write is issued.
- Write port carries at most one write per cycle. Dead pops consume an issue slot.

## Test plan
- Reset, then `alu_valid` with dest=3, data=0x5A in cycle 1 → cycle 2: `regWrite`=1, `writeReg`=3, `writeData`=0x5A; cycle 3: `regWrite`=0, `busy`=0.
- Idle, load dest=2, data=0x11 → bypass; next cycle `regWrite`=1, `writeReg`=2, `writeData`=0x11; `query_hit` never asserts.
- ALU dest=1 in cycles 1–4, loads dest=4 (0xA0) and dest=5 (0xB0) accepted in cycles 1–2:
  - cycle 3: `ld_ready`=0, `query_reg`=5 → `query_hit`=1;
  - ALU stops after cycle 4 → writes 4/0xA0 in cycle 6 and 5/0xB0 in cycle 7.
- Load dest=6, 0x77 buffered behind an ALU write; next cycle ALU dest=6, data=0x99 → 6/0x99 written, the dead load pop produces `regWrite`=0, and reg 6 is never written with 0x77.
- Same cycle: ALU dest=7 (0x01) and load dest=7 (0x02) → only 7/0x01 written; load handshake completes; a later dead pop produces no write.
- Fill buffer (2 entries), assert `reset` asynchronously mid-cycle → outputs, `busy` and `query_hit` go 0 immediately, `ld_ready`=1; no buffered write appears after release.
